global_sram_wr_ctrl: RTL and testbench
======================================

// Module: global_sram_wr_ctrl
// PURPOSE
//  Write-side controller of the global SRAM. It registers the per-layer control state, model config and start pulse.
//  In write-back states it takes the vector-out stream from the cores and issues SRAM write enable/address/data.
//  It counts embd_size/MAC_MULT_NUM words and pulses finish to the top controller.
//  In non-write states a start is acknowledged with a finish pulse, so the top FSM handshake is uniform.
// PARAMETERS
//  GSRAM_DEPTH    `GLOBAL_SRAM_DEPTH  words in global SRAM; AW = $clog2(GSRAM_DEPTH)
//  IN_ADDR_WIDTH  `CMEM_ADDR_WIDTH    width of incoming vector_out_data_addr
//  WDATA_WIDTH    128                 SRAM word width (one MAC_MULT_NUM-wide vector)
//  MAC_MULT_NUM   `MAC_MULT_NUM       elements per SRAM word; divisor for the word count
// PORTS
//  clk                   in   1              clock
//  rst                   in   1              async reset, active-high
//  control_state         in   CONTROL_STATE  next layer state
//  control_state_update  in   1              load control_state
//  model_cfg_vld         in   1              load model_cfg
//  model_cfg             in   MODEL_CONFIG   uses embd_size only
//  start                 in   1              1-cycle start pulse, aligned with the state update
//  vector_out_data_vld   in   1              write request from the cores
//  vector_out_data_addr  in   IN_ADDR_WIDTH  target word address
//  vector_out_data       in   WDATA_WIDTH    write data
//  global_sram_wen       out  1              SRAM write enable
//  global_sram_waddr     out  AW             SRAM write address
//  global_sram_wdata     out  WDATA_WIDTH    SRAM write data
//  finish                out  1              1-cycle done pulse
//  wr_err                out  1              sticky: out-of-range address or stray request
// BEHAVIOUR
//  Reset: all outputs 0. state_reg=IDLE_STATE, cfg_reg=0, start_reg=0, FSM=S_IDLE, cnt=0.
//  Input regs: control_state_update loads state_reg; model_cfg_vld loads cfg_reg. start_reg = start delayed 1 cycle (pulse).
//  N = cfg_reg.embd_size / MAC_MULT_NUM, truncated. cnt is AW+1 bits wide.
//  Write states are PROJ_STATE and FFN1_STATE (residual write-back). All other non-IDLE states are ack-only.
//  FSM S_IDLE / S_RUN:
//   - S_IDLE, start_reg, write state: cnt<=0, wr_err<=0, go to S_RUN. If N==0: finish=1 next cycle, stay in S_IDLE.
//   - S_IDLE, start_reg, ack-only state: finish=1 next cycle; no write.
//   - S_RUN, start_reg again: restart. cnt<=0 and wr_err<=0, then the same-cycle vld is counted.
//   - S_RUN, control_state_update: abort to S_IDLE. cnt<=0, no finish; an in-flight wen still completes.
//   - S_RUN, cnt reaches N: finish pulses; return to S_IDLE.
//  Accept: vld is accepted when in S_RUN, or in the start_reg cycle of a write state. That cycle counts as word 1.
//  Write path, latency 1 (registered from the accepted vld):
//   - in range (addr < GSRAM_DEPTH): wen=1, waddr=addr[AW-1:0], wdata=data.
//   - out of range: wen=0, wr_err<=1. The word is still counted.
//   - waddr and wdata hold their last value while wen=0.
//  finish is registered from the N-th accepted vld, so it is high in the same cycle as the final wen.
//  Bubbles between vld are allowed; there is no backpressure and no duplicate-address check.
//  Stray request: vld that is not accepted. It is ignored (no wen) and sets wr_err.
//  wr_err clears only on reset or on a write-state start_reg.
//  Simultaneous start_reg and control_state_update: the start applies to the already-registered state.
// TESTING
//  1 Assert rst mid-run -> next edge: wen=0, waddr=0, wdata=0, finish=0, wr_err=0, FSM S_IDLE.
//  2 FFN1, embd_size=64, MAC=16 (N=4); start at t; vld at t+1..t+4, addr 0..3, data A,B,C,D
//    -> wen t+2..t+5 at addr 0..3 with A..D; finish only at t+5.
//  3 Same as 2 with vld every 3rd cycle -> 4 wen with data intact; finish aligned with the 4th wen only.
//  4 PROJ, N=4; 2nd vld addr=GSRAM_DEPTH -> no wen for it, wr_err=1; finish still after the 4th vld.
//  5 FFN1, abort via control_state_update after 2 words -> no finish; a later vld gives no wen, wr_err=1.
//  6 ATT_QK_STATE, start at t -> finish at t+2 only; wen stays 0; N==0 in FFN1 -> finish at t+2.

Source files
------------

// File: rtl/global_sram_wr_ctrl.sv
// Write-side controller of the global SRAM: turns the cores' vector-out stream into SRAM writes
// during write-back layers and pulses finish once embd_size/MAC_MULT_NUM words have been taken.
module global_sram_wr_ctrl #(
    parameter int GSRAM_DEPTH   = 1024,
    parameter int IN_ADDR_WIDTH = 12,
    parameter int WDATA_WIDTH   = 128,
    parameter int MAC_MULT_NUM  = 16,
    parameter int CTRL_W        = 4,
    parameter int EMBD_W        = 16,
    parameter int AW            = $clog2(GSRAM_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CTRL_W-1:0]        control_state,
    input  logic                     control_state_update,
    input  logic                     model_cfg_vld,
    input  logic [EMBD_W-1:0]        model_cfg,
    input  logic                     start,
    input  logic                     vector_out_data_vld,
    input  logic [IN_ADDR_WIDTH-1:0] vector_out_data_addr,
    input  logic [WDATA_WIDTH-1:0]   vector_out_data,
    output logic                     global_sram_wen,
    output logic [AW-1:0]            global_sram_waddr,
    output logic [WDATA_WIDTH-1:0]   global_sram_wdata,
    output logic                     finish,
    output logic                     wr_err
);

    localparam logic [CTRL_W-1:0] IDLE_STATE   = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] ATT_QK_STATE = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] ATT_PV_STATE = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] PROJ_STATE   = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] FFN0_STATE   = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] FFN1_STATE   = CTRL_W'(5);

    localparam int CW = (EMBD_W > AW + 1) ? EMBD_W : AW + 1;
    localparam logic [IN_ADDR_WIDTH:0] DEPTH_X = (IN_ADDR_WIDTH + 1)'(GSRAM_DEPTH);

    typedef enum logic {S_IDLE, S_RUN} fsm_t;

    fsm_t               fsm, fsm_nxt;
    logic [CTRL_W-1:0]  state_reg;
    logic [EMBD_W-1:0]  embd_reg;
    logic               start_reg;
    logic [AW:0]        cnt, cnt_nxt, cnt_base, cnt_inc;
    logic [EMBD_W-1:0]  n_words;
    logic               n_zero, wr_state, start_wr, start_ack, accept, in_range;
    logic               fin_nxt, err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE_STATE;
            embd_reg  <= '0;
            start_reg <= 1'b0;
        end else begin
            if (control_state_update) state_reg <= control_state;
            if (model_cfg_vld)        embd_reg  <= model_cfg;
            start_reg <= start;
        end
    end

    assign n_words   = embd_reg / EMBD_W'(MAC_MULT_NUM);
    assign n_zero    = (n_words == '0);
    assign wr_state  = (state_reg == PROJ_STATE) || (state_reg == FFN1_STATE);
    assign start_wr  = start_reg && wr_state;
    assign start_ack = start_reg && !wr_state && (state_reg != IDLE_STATE);
    // The start cycle of a write layer already carries word 1.
    assign accept    = vector_out_data_vld && ((fsm == S_RUN) || (start_wr && !n_zero));
    assign in_range  = {1'b0, vector_out_data_addr} < DEPTH_X;

    always_comb begin
        fsm_nxt  = fsm;
        cnt_nxt  = cnt;
        fin_nxt  = 1'b0;
        err_nxt  = wr_err;
        cnt_base = start_wr ? '0 : cnt;
        cnt_inc  = cnt_base + (AW + 1)'(accept);
        if (start_wr) err_nxt = 1'b0;
        case (fsm)
            S_IDLE: begin
                if (start_wr) begin
                    if (n_zero) fin_nxt = 1'b1;
                    else begin
                        fsm_nxt = S_RUN;
                        cnt_nxt = cnt_inc;
                    end
                end else if (start_ack) begin
                    fin_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (start_wr) begin
                    cnt_nxt = cnt_inc;
                end else if (control_state_update) begin
                    fsm_nxt = S_IDLE;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: fsm_nxt = S_IDLE;
        endcase
        if (fsm_nxt == S_RUN && accept && CW'(cnt_inc) == CW'(n_words)) begin
            fin_nxt = 1'b1;
            fsm_nxt = S_IDLE;
            cnt_nxt = '0;
        end
        // Setting wins over the start-time clear so a bad first word is still flagged.
        if ((vector_out_data_vld && !accept) || (accept && !in_range)) err_nxt = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm               <= S_IDLE;
            cnt               <= '0;
            finish            <= 1'b0;
            wr_err            <= 1'b0;
            global_sram_wen   <= 1'b0;
            global_sram_waddr <= '0;
            global_sram_wdata <= '0;
        end else begin
            fsm             <= fsm_nxt;
            cnt             <= cnt_nxt;
            finish          <= fin_nxt;
            wr_err          <= err_nxt;
            global_sram_wen <= accept && in_range;
            if (accept && in_range) begin
                global_sram_waddr <= vector_out_data_addr[AW-1:0];
                global_sram_wdata <= vector_out_data;
            end
        end
    end

endmodule

// File: tb/tb_global_sram_wr_ctrl.sv
// Bench for global_sram_wr_ctrl: directed jobs build a cycle-indexed expectation map that a
// per-cycle compare process checks, plus literal per-test totals.
module tb_global_sram_wr_ctrl;

    localparam int DEPTH = 1024;
    localparam int IAW   = 12;
    localparam int DW    = 128;
    localparam int MAC   = 16;
    localparam int EW    = 16;
    localparam int AW    = 10;
    localparam logic [3:0] IDLE_S = 4'd0, ATTQK_S = 4'd1, PROJ_S = 4'd3, FFN1_S = 4'd5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [3:0]      control_state = '0;
    logic            control_state_update = 1'b0;
    logic            model_cfg_vld = 1'b0;
    logic [EW-1:0]   model_cfg = '0;
    logic            start = 1'b0;
    logic            vector_out_data_vld = 1'b0;
    logic [IAW-1:0]  vector_out_data_addr = '0;
    logic [DW-1:0]   vector_out_data = '0;
    logic            global_sram_wen;
    logic [AW-1:0]   global_sram_waddr;
    logic [DW-1:0]   global_sram_wdata;
    logic            finish;
    logic            wr_err;

    global_sram_wr_ctrl #(
        .GSRAM_DEPTH(DEPTH), .IN_ADDR_WIDTH(IAW), .WDATA_WIDTH(DW), .MAC_MULT_NUM(MAC),
        .CTRL_W(4), .EMBD_W(EW)
    ) dut (
        .clk(clk), .rst(rst),
        .control_state(control_state), .control_state_update(control_state_update),
        .model_cfg_vld(model_cfg_vld), .model_cfg(model_cfg), .start(start),
        .vector_out_data_vld(vector_out_data_vld), .vector_out_data_addr(vector_out_data_addr),
        .vector_out_data(vector_out_data),
        .global_sram_wen(global_sram_wen), .global_sram_waddr(global_sram_waddr),
        .global_sram_wdata(global_sram_wdata), .finish(finish), .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Expected behaviour per cycle: which cycles carry a write (and what), which carry finish,
    // and the cycles where the error flag is expected to change.
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    wr_t exp_wr[int];
    bit  exp_fin[int];
    bit  exp_err_chg[int];
    bit  chk_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit  m_err = 1'b0;
    int  wen_cnt = 0;
    int  fin_cnt = 0;

    always @(negedge clk) begin
        bit e_wen, e_fin;
        if (chk_en) begin
            e_wen = exp_wr.exists(cyc);
            if (e_wen) begin
                m_addr = exp_wr[cyc].a;
                m_data = exp_wr[cyc].d;
            end
            e_fin = exp_fin.exists(cyc);
            if (exp_err_chg.exists(cyc)) m_err = exp_err_chg[cyc];
            chk("wen",    DW'(global_sram_wen),   DW'(e_wen));
            chk("waddr",  DW'(global_sram_waddr), DW'(m_addr));
            chk("wdata",  global_sram_wdata,      m_data);
            chk("finish", DW'(finish),            DW'(e_fin));
            chk("wr_err", DW'(wr_err),            DW'(m_err));
            wen_cnt += int'(global_sram_wen);
            fin_cnt += int'(finish);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] word_data(input int seed, input int k);
        logic [31:0] w;
        w = 32'hA5A5_0000 + 32'(seed * 16 + k);
        return {w, ~w, w ^ 32'h0F0F_F0F0, 32'(k)};
    endfunction

    // One layer: start with a state/config at cycle t, then feed words with a fixed gap.
    // bad_k marks the word sent to an out-of-range address; abort_k aborts before that word.
    task automatic job(input logic [3:0] st, input int embd, input int gap, input int bad_k,
                       input int abort_k, input int base, input int seed);
        int t, n, c, a;
        bit wr;
        logic [DW-1:0] d;
        wr = (st == PROJ_S) || (st == FFN1_S);
        n  = embd / MAC;
        t  = cyc;
        control_state = st; control_state_update = 1'b1;
        model_cfg = EW'(embd); model_cfg_vld = 1'b1; start = 1'b1;
        if (wr) exp_err_chg[t + 2] = 1'b0;
        if (!wr || n == 0) exp_fin[t + 2] = 1'b1;
        tick();
        control_state_update = 1'b0; model_cfg_vld = 1'b0; start = 1'b0;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                if (k == abort_k) begin
                    control_state_update = 1'b1;
                    tick();
                    control_state_update = 1'b0;
                    c = cyc;
                    vector_out_data_vld = 1'b1;
                    vector_out_data_addr = IAW'(base + 7);
                    vector_out_data = word_data(seed, 99);
                    exp_err_chg[c + 1] = 1'b1;
                    tick();
                    vector_out_data_vld = 1'b0;
                    break;
                end
                if (k > 0) repeat (gap - 1) tick();
                c = cyc;
                a = (k == bad_k) ? DEPTH : base + k;
                d = word_data(seed, k);
                vector_out_data_vld = 1'b1;
                vector_out_data_addr = IAW'(a);
                vector_out_data = d;
                if (a < DEPTH) exp_wr[c + 1] = '{a: AW'(a), d: d};
                else exp_err_chg[c + 1] = 1'b1;
                if (k == n - 1) exp_fin[c + 1] = 1'b1;
                tick();
                vector_out_data_vld = 1'b0;
            end
        end
        repeat (4) tick();
    endtask

    task automatic clr_cnt();
        wen_cnt = 0;
        fin_cnt = 0;
    endtask

    initial begin
        int c;
        #1;
        chk("rst_wen",    DW'(global_sram_wen),   '0);
        chk("rst_waddr",  DW'(global_sram_waddr), '0);
        chk("rst_finish", DW'(finish),            '0);
        chk("rst_wr_err", DW'(wr_err),            '0);
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // FFN1, N=4, back-to-back words
        clr_cnt();
        job(FFN1_S, 64, 1, -1, -1, 0, 1);
        chk("t2_wen_cnt", DW'(wen_cnt), DW'(4));
        chk("t2_fin_cnt", DW'(fin_cnt), DW'(1));
        chk("t2_last_addr", DW'(global_sram_waddr), DW'(3));
        chk("t2_last_data", global_sram_wdata, word_data(1, 3));

        // Same job with a word every third cycle
        clr_cnt();
        job(FFN1_S, 64, 3, -1, -1, 100, 2);
        chk("t3_wen_cnt", DW'(wen_cnt), DW'(4));
        chk("t3_fin_cnt", DW'(fin_cnt), DW'(1));

        // PROJ with the second word out of range
        clr_cnt();
        job(PROJ_S, 64, 1, 1, -1, 200, 3);
        chk("t4_wen_cnt", DW'(wen_cnt), DW'(3));
        chk("t4_fin_cnt", DW'(fin_cnt), DW'(1));
        chk("t4_wr_err",  DW'(wr_err),  DW'(1));

        // FFN1 aborted after two words, then a stray request
        clr_cnt();
        job(FFN1_S, 64, 1, -1, 2, 300, 4);
        chk("t5_wen_cnt", DW'(wen_cnt), DW'(2));
        chk("t5_fin_cnt", DW'(fin_cnt), DW'(0));
        chk("t5_wr_err",  DW'(wr_err),  DW'(1));

        // Ack-only layer, then a write layer with N==0
        clr_cnt();
        job(ATTQK_S, 64, 1, -1, -1, 0, 5);
        chk("t6_ack_fin",  DW'(fin_cnt), DW'(1));
        chk("t6_ack_wen",  DW'(wen_cnt), DW'(0));
        chk("t6_ack_err",  DW'(wr_err),  DW'(1));
        clr_cnt();
        job(FFN1_S, 8, 1, -1, -1, 0, 6);
        chk("t6_n0_fin", DW'(fin_cnt), DW'(1));
        chk("t6_n0_wen", DW'(wen_cnt), DW'(0));
        chk("t6_n0_err", DW'(wr_err),  DW'(0));

        // Reset in the middle of a run
        c = cyc;
        control_state = FFN1_S; control_state_update = 1'b1;
        model_cfg = EW'(64); model_cfg_vld = 1'b1; start = 1'b1;
        exp_err_chg[c + 2] = 1'b0;
        tick();
        control_state_update = 1'b0; model_cfg_vld = 1'b0; start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            c = cyc;
            vector_out_data_vld = 1'b1;
            vector_out_data_addr = IAW'(500 + k);
            vector_out_data = word_data(7, k);
            exp_wr[c + 1] = '{a: AW'(500 + k), d: word_data(7, k)};
            tick();
        end
        vector_out_data_vld = 1'b0;
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("t1_wen",    DW'(global_sram_wen),   '0);
        chk("t1_waddr",  DW'(global_sram_waddr), '0);
        chk("t1_wdata",  global_sram_wdata,      '0);
        chk("t1_finish", DW'(finish),            '0);
        chk("t1_wr_err", DW'(wr_err),            '0);
        tick();
        rst = 1'b0;
        exp_wr.delete(); exp_fin.delete(); exp_err_chg.delete();
        m_addr = '0; m_data = '0; m_err = 1'b0;
        chk_en = 1'b1;
        tick();
        // FSM must be idle now: a request without start is a stray
        clr_cnt();
        c = cyc;
        vector_out_data_vld = 1'b1;
        vector_out_data_addr = IAW'(5);
        exp_err_chg[c + 1] = 1'b1;
        tick();
        vector_out_data_vld = 1'b0;
        repeat (3) tick();
        chk("t1_post_wen", DW'(wen_cnt), DW'(0));
        chk("t1_post_err", DW'(wr_err),  DW'(1));

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
